rs_issue_queue: RTL and testbench
=================================

# rs_issue_queue

Parametrised out-of-order issue queue, the next-generation reservation station. It sits between rename/dispatch and the functional units (FUs). It buffers up to DEPTH renamed instructions and captures operand values from NUM_WAKE broadcast buses. Each cycle it issues the oldest ready entries to up to NUM_FU ready FUs. Unlike the previous generation, entries are not bound to an FU at dispatch, selection is oldest-first, dispatch has backpressure and a flush input is provided.

## Interface
Parameters:
- DEPTH, 16: number of entries (power of 2, ≥2).
- NUM_FU, 3: number of issue ports / FUs.
- NUM_WAKE, 4: number of wakeup/forwarding buses.
- TAG_W, 6: physical register tag width.
- ROB_W, 6: ROB index width.
- DATA_W, 32: operand and immediate width.

Ports (port `i` refers to FU or issue port `i`):
- Clock and reset (already decided): one clock, `clk`; reset `reset` is synchronous and active-high.
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- flush, in, 1: discard all entries and pending issues.
- disp_valid, in, 1: dispatch request.
- disp_ready, out, 1: `count < DEPTH`.
- disp_rd, disp_rs1, disp_rs2, in, TAG_W each: destination and source tags.
- disp_rs1_rdy, disp_rs2_rdy, in, 1 each: source value already valid.
- disp_rs1_val, disp_rs2_val, disp_imm, in, DATA_W each.
- disp_alu_op, in, 4; disp_is_ls, in, 1; disp_alusrc, in, 1; disp_rob, in, ROB_W.
- wake_valid, in, NUM_WAKE; wake_tag, in, NUM_WAKE*TAG_W; wake_val, in, NUM_WAKE*DATA_W. Bus `w` occupies slice `w`.
- fu_ready, in, NUM_FU: FU `i` can accept an issue this cycle.
- iss_valid, out, NUM_FU.
- iss_rd, out, NUM_FU*TAG_W; iss_rob, out, NUM_FU*ROB_W.
- iss_rs1_val, iss_rs2_val, iss_imm, out, NUM_FU*DATA_W each.
- iss_alu_op, out, NUM_FU*4; iss_is_ls, out, NUM_FU; iss_alusrc, out, NUM_FU.
- count, out, $clog2(DEPTH)+1: number of occupied entries.

## Operation
- **Entry contents.** Each entry holds: valid, the dispatch fields, rs1/rs2 ready and value, and an age-matrix row.
- **Dispatch.**
  - A dispatch is accepted when `disp_valid && disp_ready && !flush`.
  - It writes the lowest-index free entry.
  - Any `disp_alu_op` value is accepted, including 0.
- **Dispatch-cycle capture.** If a source is not ready and matches a valid wakeup tag in the same cycle, the entry is written with that value and marked ready. This closes the dispatch/wakeup race.
- **Wakeup.**
  - For every valid entry and each not-ready source: if `wake_valid[w] && wake_tag[w] == src_tag`, capture `wake_val[w]` and set ready.
  - If several buses match, the lowest `w` wins.
  - Already-ready sources ignore wakeups.
- **Select.**
  - Candidates are valid entries with both sources ready, taken from registered state.
  - The k-th oldest candidate goes to the k-th set bit of `fu_ready` (ascending FU index).
  - At most min(popcount(`fu_ready`), NUM_FU) entries issue per cycle.
  - Extra candidates wait; they are never dropped.
- **Issue and free.** An issued entry's fields are registered onto its port with `iss_valid[i]` set, and the entry is freed at the same edge.
- **Age tracking.** On dispatch, the new entry's row is set to "older-than-me" for every currently valid entry. Freeing an entry clears its column.
- **Flush.** All entries and all `iss_valid` are cleared at the edge. Flush overrides dispatch and issue in the same cycle.
- **count.** `count_next = count + accepted − issued`, computed in the same cycle. Dispatch and issue in one cycle both take effect.

## Timing
- **Reset values.** `count` = 0, all `iss_valid` = 0, all `iss_*` data = 0, all entries invalid; hence `disp_ready` = 1.
- **Dispatch to issue.** An entry dispatched fully ready at edge N is selectable in cycle N+1; `iss_valid` goes high after edge N+1.
- **Wakeup to issue.** A wakeup in cycle N readies its entry at edge N. The earliest issue is visible after edge N+1.
- **Issue hold.** `iss_valid[i]` is a one-cycle pulse per issue. It deasserts the next cycle unless a new issue occurs on that port.
- **Backpressure.** `disp_ready` is combinational from registered `count` only. An entry freed in cycle N does not raise `disp_ready` until cycle N+1.
- **Full queue.** When the queue is full, a dispatch is rejected and state is unchanged.
- **Empty queue.** When the queue is empty, no issue occurs and `iss_valid` = 0.
- **Reset or flush mid-stream.** Reset or flush takes effect at the next edge and drops in-flight issues. Wakeups in that same cycle are ignored.

## Structure
- Shared package `rs_pkg`:
  - entry struct/field offsets;
  - `ALU_OP_W` = 4;
  - a `first_free` function;
  - a `lowest_set` priority function.
- Sub-module `rs_age_matrix`:
  - DEPTH×DEPTH matrix with dispatch set and free clear;
  - outputs one oldest-ready one-hot per issue port, using iterative masking of already-picked entries.
- Top level holds the entry array, wakeup CAM, FU steering and the issue registers.

## Test plan
- **Ready dispatch.** Reset, then dispatch one fully ready entry (rob=5, rs1=0x10, rs2=0x20) with `fu_ready`=3'b111 → `iss_valid`=3'b001 one cycle after dispatch, iss_rob[0]=5, `count` back to 0.
- **Oldest-first.** Dispatch A (rs1 tag 9, not ready) then B (ready), with only FU2 ready → B issues on FU2. Then `wake_tag[3]`=9, `wake_val`=0xDEAD → A issues next cycle with iss_rs1_val=0xDEAD.
- **Dispatch/wakeup race.** Dispatch rs2 tag 12 not ready while `wake_valid[0]`, tag 12, val 0x55 in the same cycle → entry issues with rs2=0x55 and no further wakeup is needed.
- **Fill and drain.** Fill DEPTH entries with ready ops and `fu_ready`=0 → `disp_ready`=0 and a 17th dispatch is ignored. Then set `fu_ready`=3'b101 → 2 issues per cycle in dispatch order on FU0/FU2, `count` falls by 2 per cycle.
- **Flush vs dispatch.** Flush asserted together with a dispatch while 5 entries are pending → `count`=0, no issue the following cycle, `disp_ready`=1.
- **Parameter sweep.** DEPTH=4, NUM_FU=1, NUM_WAKE=2 → all of the above hold.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
// Vector helpers work on a fixed 64-bit vector; callers size-cast to DEPTH.
package rs_pkg;
  localparam int ALU_OP_W  = 4;
  localparam int MAX_DEPTH = 64;

  typedef logic [MAX_DEPTH-1:0] vec_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                is_ls;
    logic                alusrc;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic vec_t lowest_set(vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  function automatic vec_t first_free(vec_t valid);
    return lowest_set(~valid);
  endfunction
endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch / wakeup / issue bundle for rs_issue_queue.
// The master side drives dispatch, wakeup, flush and FU readiness.
interface rs_issue_queue_if
  import rs_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_FU   = 3,
  parameter int NUM_WAKE = 4,
  parameter int TAG_W    = 6,
  parameter int ROB_W    = 6,
  parameter int DATA_W   = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         flush;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [TAG_W-1:0]             disp_rd, disp_rs1, disp_rs2;
  logic                         disp_rs1_rdy, disp_rs2_rdy;
  logic [DATA_W-1:0]            disp_rs1_val, disp_rs2_val, disp_imm;
  logic [ALU_OP_W-1:0]          disp_alu_op;
  logic                         disp_is_ls, disp_alusrc;
  logic [ROB_W-1:0]             disp_rob;
  logic [NUM_WAKE-1:0]          wake_valid;
  logic [NUM_WAKE*TAG_W-1:0]    wake_tag;
  logic [NUM_WAKE*DATA_W-1:0]   wake_val;
  logic [NUM_FU-1:0]            fu_ready;
  logic [NUM_FU-1:0]            iss_valid;
  logic [NUM_FU*TAG_W-1:0]      iss_rd;
  logic [NUM_FU*ROB_W-1:0]      iss_rob;
  logic [NUM_FU*DATA_W-1:0]     iss_rs1_val, iss_rs2_val, iss_imm;
  logic [NUM_FU*ALU_OP_W-1:0]   iss_alu_op;
  logic [NUM_FU-1:0]            iss_is_ls, iss_alusrc;
  logic [CNT_W-1:0]             count;

  modport master (
    output flush, disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_val, disp_rs2_val, disp_imm, disp_alu_op, disp_is_ls, disp_alusrc,
           disp_rob, wake_valid, wake_tag, wake_val, fu_ready,
    input  disp_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val, iss_imm,
           iss_alu_op, iss_is_ls, iss_alusrc, count
  );

  modport slave (
    input  flush, disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_val, disp_rs2_val, disp_imm, disp_alu_op, disp_is_ls, disp_alusrc,
           disp_rob, wake_valid, wake_tag, wake_val, fu_ready,
    output disp_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val, iss_imm,
           iss_alu_op, iss_is_ls, iss_alusrc, count
  );
endinterface

// File: rtl/rs_issue_queue_age_matrix.sv
// Age matrix: row r holds the entries older than entry r.
// Emits the k-th oldest candidate per port by masking earlier picks.
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [DEPTH-1:0]              alloc_i,
  input  logic [DEPTH-1:0]              free_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0]              cand_i,
  output logic [NUM_FU-1:0][DEPTH-1:0]  oldest_o
);
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] remaining;
  logic [DEPTH-1:0] pick;

  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (reset || flush_i) begin
        age_q[r] <= '0;
      end else if (alloc_i[r]) begin
        age_q[r] <= valid_i & ~free_i;
      end else begin
        age_q[r] <= age_q[r] & ~free_i;
      end
    end
  end

  // An entry is oldest when no remaining candidate is older than it.
  always_comb begin
    remaining = cand_i;
    pick      = '0;
    oldest_o  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int r = 0; r < DEPTH; r++) begin
        pick[r] = remaining[r] && ((age_q[r] & remaining) == '0);
      end
      pick        = DEPTH'(lowest_set(vec_t'(pick)));
      oldest_o[k] = pick;
      remaining   = remaining & ~pick;
    end
  end
endmodule

// File: rtl/rs_issue_queue.sv
// Out-of-order issue queue: entry array, wakeup CAM, oldest-first select
// steered onto ready FUs, and registered issue ports.
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_FU   = 3,
  parameter int NUM_WAKE = 4,
  parameter int TAG_W    = 6,
  parameter int ROB_W    = 6,
  parameter int DATA_W   = 32
) (
  input logic        clk,
  input logic        reset,
  rs_issue_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  valid_q, rs1_rdy_q, rs2_rdy_q;
  logic [TAG_W-1:0]  rd_q [DEPTH], rs1_tag_q [DEPTH], rs2_tag_q [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [DATA_W-1:0] rs1_val_q [DEPTH], rs2_val_q [DEPTH], imm_q [DEPTH];
  ctrl_t             ctrl_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_FU-1:0]          iss_valid_q, iss_valid_d;
  logic [NUM_FU*TAG_W-1:0]    iss_rd_q;
  logic [NUM_FU*ROB_W-1:0]    iss_rob_q;
  logic [NUM_FU*DATA_W-1:0]   iss_rs1_q, iss_rs2_q, iss_imm_q;
  logic [NUM_FU*ALU_OP_W-1:0] iss_alu_op_q;
  logic [NUM_FU-1:0]          iss_is_ls_q, iss_alusrc_q;

  logic                        fire;
  logic [DEPTH-1:0]            cand, alloc, free_mask;
  logic [NUM_FU-1:0][DEPTH-1:0] oldest, gnt;
  int                          rank, issued;
  logic [DATA_W:0]             wk1 [DEPTH], wk2 [DEPTH];
  logic [DATA_W:0]             dwk1, dwk2;
  logic [TAG_W-1:0]            sel_rd [NUM_FU];
  logic [ROB_W-1:0]            sel_rob [NUM_FU];
  logic [DATA_W-1:0]           sel_rs1 [NUM_FU], sel_rs2 [NUM_FU], sel_imm [NUM_FU];
  ctrl_t                       sel_ctrl [NUM_FU];

  // Returns {hit, value}; iterating downward lets the lowest bus win.
  function automatic logic [DATA_W:0] wake_match(
    input logic [TAG_W-1:0]           tag,
    input logic [NUM_WAKE-1:0]        wv,
    input logic [NUM_WAKE*TAG_W-1:0]  wt,
    input logic [NUM_WAKE*DATA_W-1:0] wd
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int w = NUM_WAKE - 1; w >= 0; w--) begin
      if (wv[w] && (wt[w*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, wd[w*DATA_W +: DATA_W]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign fire  = bus.disp_valid && bus.disp_ready && !bus.flush;
  assign alloc = fire ? DEPTH'(first_free(vec_t'(valid_q))) : '0;
  assign cand  = valid_q & rs1_rdy_q & rs2_rdy_q;

  rs_age_matrix #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) u_age (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (bus.flush),
    .alloc_i  (alloc),
    .free_i   (free_mask),
    .valid_i  (valid_q),
    .cand_i   (cand),
    .oldest_o (oldest)
  );

  // The k-th ready FU (ascending index) takes the k-th oldest candidate.
  always_comb begin
    rank      = 0;
    issued    = 0;
    gnt       = '0;
    free_mask = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (bus.fu_ready[i] && (rank == k)) begin
          gnt[i] = oldest[k];
        end else begin
          gnt[i] = gnt[i];
        end
      end
      rank           = rank + (bus.fu_ready[i] ? 1 : 0);
      iss_valid_d[i] = |gnt[i];
      issued         = issued + (iss_valid_d[i] ? 1 : 0);
      free_mask      = free_mask | gnt[i];
    end
    count_d = count_q + CNT_W'(fire) - CNT_W'(issued);
  end

  always_comb begin
    dwk1 = wake_match(bus.disp_rs1, bus.wake_valid, bus.wake_tag, bus.wake_val);
    dwk2 = wake_match(bus.disp_rs2, bus.wake_valid, bus.wake_tag, bus.wake_val);
    for (int e = 0; e < DEPTH; e++) begin
      wk1[e] = wake_match(rs1_tag_q[e], bus.wake_valid, bus.wake_tag, bus.wake_val);
      wk2[e] = wake_match(rs2_tag_q[e], bus.wake_valid, bus.wake_tag, bus.wake_val);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      sel_rd[i] = '0; sel_rob[i] = '0; sel_rs1[i] = '0;
      sel_rs2[i] = '0; sel_imm[i] = '0; sel_ctrl[i] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        sel_rd[i]   = sel_rd[i]   | (rd_q[e]      & {TAG_W{gnt[i][e]}});
        sel_rob[i]  = sel_rob[i]  | (rob_q[e]     & {ROB_W{gnt[i][e]}});
        sel_rs1[i]  = sel_rs1[i]  | (rs1_val_q[e] & {DATA_W{gnt[i][e]}});
        sel_rs2[i]  = sel_rs2[i]  | (rs2_val_q[e] & {DATA_W{gnt[i][e]}});
        sel_imm[i]  = sel_imm[i]  | (imm_q[e]     & {DATA_W{gnt[i][e]}});
        sel_ctrl[i] = sel_ctrl[i] | (ctrl_q[e]    & {CTRL_W{gnt[i][e]}});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      iss_valid_q  <= '0;
      iss_rd_q     <= '0;
      iss_rob_q    <= '0;
      iss_rs1_q    <= '0;
      iss_rs2_q    <= '0;
      iss_imm_q    <= '0;
      iss_alu_op_q <= '0;
      iss_is_ls_q  <= '0;
      iss_alusrc_q <= '0;
    end else if (bus.flush) begin
      valid_q     <= '0;
      count_q     <= '0;
      iss_valid_q <= '0;
    end else begin
      valid_q     <= (valid_q & ~free_mask) | alloc;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      for (int i = 0; i < NUM_FU; i++) begin
        if (iss_valid_d[i]) begin
          iss_rd_q[i*TAG_W +: TAG_W]         <= sel_rd[i];
          iss_rob_q[i*ROB_W +: ROB_W]        <= sel_rob[i];
          iss_rs1_q[i*DATA_W +: DATA_W]      <= sel_rs1[i];
          iss_rs2_q[i*DATA_W +: DATA_W]      <= sel_rs2[i];
          iss_imm_q[i*DATA_W +: DATA_W]      <= sel_imm[i];
          iss_alu_op_q[i*ALU_OP_W +: ALU_OP_W] <= sel_ctrl[i].alu_op;
          iss_is_ls_q[i]                     <= sel_ctrl[i].is_ls;
          iss_alusrc_q[i]                    <= sel_ctrl[i].alusrc;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (alloc[e]) begin
        rd_q[e]      <= bus.disp_rd;
        rs1_tag_q[e] <= bus.disp_rs1;
        rs2_tag_q[e] <= bus.disp_rs2;
        rob_q[e]     <= bus.disp_rob;
        imm_q[e]     <= bus.disp_imm;
        ctrl_q[e]    <= '{alu_op: bus.disp_alu_op, is_ls: bus.disp_is_ls, alusrc: bus.disp_alusrc};
        rs1_rdy_q[e] <= bus.disp_rs1_rdy | dwk1[DATA_W];
        rs2_rdy_q[e] <= bus.disp_rs2_rdy | dwk2[DATA_W];
        rs1_val_q[e] <= (!bus.disp_rs1_rdy && dwk1[DATA_W]) ? dwk1[DATA_W-1:0] : bus.disp_rs1_val;
        rs2_val_q[e] <= (!bus.disp_rs2_rdy && dwk2[DATA_W]) ? dwk2[DATA_W-1:0] : bus.disp_rs2_val;
      end else begin
        if (!rs1_rdy_q[e] && wk1[e][DATA_W]) begin
          rs1_rdy_q[e] <= 1'b1;
          rs1_val_q[e] <= wk1[e][DATA_W-1:0];
        end
        if (!rs2_rdy_q[e] && wk2[e][DATA_W]) begin
          rs2_rdy_q[e] <= 1'b1;
          rs2_val_q[e] <= wk2[e][DATA_W-1:0];
        end
      end
    end
  end

  assign bus.disp_ready  = (count_q < CNT_W'(DEPTH));
  assign bus.count       = count_q;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_rd      = iss_rd_q;
  assign bus.iss_rob     = iss_rob_q;
  assign bus.iss_rs1_val = iss_rs1_q;
  assign bus.iss_rs2_val = iss_rs2_q;
  assign bus.iss_imm     = iss_imm_q;
  assign bus.iss_alu_op  = iss_alu_op_q;
  assign bus.iss_is_ls   = iss_is_ls_q;
  assign bus.iss_alusrc  = iss_alusrc_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed self-checking bench for rs_issue_queue: default build plus a
// DEPTH=4 / NUM_FU=1 / NUM_WAKE=2 instance.
module tb_rs_issue_queue;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rs_issue_queue_if #(.DEPTH(16), .NUM_FU(3), .NUM_WAKE(4),
                      .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();
  rs_issue_queue_if #(.DEPTH(4), .NUM_FU(1), .NUM_WAKE(2),
                      .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus2 ();

  rs_issue_queue #(.DEPTH(16), .NUM_FU(3), .NUM_WAKE(4),
                   .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  rs_issue_queue #(.DEPTH(4), .NUM_FU(1), .NUM_WAKE(2),
                   .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Side fields are derived from rob so expectations can be recomputed.
  task automatic disp(input logic [ROB_W-1:0] rob,
                      input logic [TAG_W-1:0] rs1, input logic r1, input logic [31:0] v1,
                      input logic [TAG_W-1:0] rs2, input logic r2, input logic [31:0] v2);
    bus.disp_valid   = 1'b1;
    bus.disp_rob     = rob;
    bus.disp_rd      = rob ^ 6'h2A;
    bus.disp_rs1     = rs1;  bus.disp_rs1_rdy = r1;  bus.disp_rs1_val = v1;
    bus.disp_rs2     = rs2;  bus.disp_rs2_rdy = r2;  bus.disp_rs2_val = v2;
    bus.disp_imm     = 32'h1000 + 32'(rob);
    bus.disp_alu_op  = rob[3:0] ^ 4'h5;
    bus.disp_is_ls   = rob[0];
    bus.disp_alusrc  = rob[1];
  endtask

  task automatic disp2(input logic [ROB_W-1:0] rob, input logic [TAG_W-1:0] rs1,
                       input logic r1, input logic [31:0] v1);
    bus2.disp_valid   = 1'b1;
    bus2.disp_rob     = rob;
    bus2.disp_rd      = rob;
    bus2.disp_rs1     = rs1;  bus2.disp_rs1_rdy = r1;  bus2.disp_rs1_val = v1;
    bus2.disp_rs2     = 6'd0; bus2.disp_rs2_rdy = 1'b1; bus2.disp_rs2_val = 32'h0;
    bus2.disp_imm     = 32'h0;
    bus2.disp_alu_op  = 4'h0;
    bus2.disp_is_ls   = 1'b0;
    bus2.disp_alusrc  = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;  bus.disp_valid = 1'b0;  bus.fu_ready = 3'b000;
    bus.wake_valid = 4'b0000;  bus.wake_tag = '0;  bus.wake_val = '0;
    disp(6'd0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
    bus.disp_valid = 1'b0;
    bus2.flush = 1'b0; bus2.fu_ready = 1'b0;
    bus2.wake_valid = 2'b00; bus2.wake_tag = '0; bus2.wake_val = '0;
    disp2(6'd0, 6'd0, 1'b1, 32'h0);
    bus2.disp_valid = 1'b0;

    step(); step();
    reset = 1'b0;
    check("reset_count", 64'(bus.count), 64'd0);
    check("reset_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("reset_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("reset_iss_rob", 64'(bus.iss_rob), 64'd0);
    check("reset_iss_rs1", 64'(bus.iss_rs1_val), 64'd0);
    check("reset2_disp_ready", 64'(bus2.disp_ready), 64'd1);

    // Ready dispatch, alu_op 0 (5 ^ 5)
    bus.fu_ready = 3'b111;
    disp(6'd5, 6'd1, 1'b1, 32'h10, 6'd2, 1'b1, 32'h20);
    step();
    bus.disp_valid = 1'b0;
    check("rd_count_after_disp", 64'(bus.count), 64'd1);
    check("rd_no_issue_yet", 64'(bus.iss_valid), 64'd0);
    step();
    check("rd_iss_valid", 64'(bus.iss_valid), 64'b001);
    check("rd_iss_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'd5);
    check("rd_iss_rs1", 64'(bus.iss_rs1_val[0 +: DATA_W]), 64'h10);
    check("rd_iss_rs2", 64'(bus.iss_rs2_val[0 +: DATA_W]), 64'h20);
    check("rd_iss_rd", 64'(bus.iss_rd[0 +: TAG_W]), 64'(6'd5 ^ 6'h2A));
    check("rd_iss_imm", 64'(bus.iss_imm[0 +: DATA_W]), 64'h1005);
    check("rd_iss_alu_op", 64'(bus.iss_alu_op[0 +: 4]), 64'd0);
    check("rd_iss_is_ls", 64'(bus.iss_is_ls[0]), 64'd1);
    check("rd_count_back", 64'(bus.count), 64'd0);
    step();
    check("rd_pulse_drop", 64'(bus.iss_valid), 64'd0);

    // Oldest-first with only FU2 ready
    bus.fu_ready = 3'b100;
    disp(6'd1, 6'd9, 1'b0, 32'h0, 6'd3, 1'b1, 32'h2);
    step();
    disp(6'd2, 6'd4, 1'b1, 32'h44, 6'd5, 1'b1, 32'h55);
    step();
    bus.disp_valid = 1'b0;
    check("of_no_issue_a", 64'(bus.iss_valid), 64'd0);
    step();
    check("of_b_valid", 64'(bus.iss_valid), 64'b100);
    check("of_b_rob", 64'(bus.iss_rob[2*ROB_W +: ROB_W]), 64'd2);
    check("of_b_alu_op", 64'(bus.iss_alu_op[2*4 +: 4]), 64'(4'd2 ^ 4'h5));
    check("of_b_alusrc", 64'(bus.iss_alusrc[2]), 64'd1);
    bus.wake_valid = 4'b1000;
    bus.wake_tag[3*TAG_W +: TAG_W]   = 6'd9;
    bus.wake_val[3*DATA_W +: DATA_W] = 32'hDEAD;
    step();
    bus.wake_valid = 4'b0000;
    check("of_wake_cycle_idle", 64'(bus.iss_valid), 64'd0);
    step();
    check("of_a_valid", 64'(bus.iss_valid), 64'b100);
    check("of_a_rob", 64'(bus.iss_rob[2*ROB_W +: ROB_W]), 64'd1);
    check("of_a_rs1", 64'(bus.iss_rs1_val[2*DATA_W +: DATA_W]), 64'hDEAD);
    check("of_a_rs2", 64'(bus.iss_rs2_val[2*DATA_W +: DATA_W]), 64'h2);
    check("of_count", 64'(bus.count), 64'd0);
    step();

    // Dispatch/wakeup race; bus 0 must beat bus 1 on the same tag
    bus.fu_ready = 3'b111;
    disp(6'd3, 6'd7, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0);
    bus.wake_valid = 4'b0011;
    bus.wake_tag[0 +: TAG_W] = 6'd12;   bus.wake_val[0 +: DATA_W] = 32'h55;
    bus.wake_tag[TAG_W +: TAG_W] = 6'd12; bus.wake_val[DATA_W +: DATA_W] = 32'h77;
    step();
    bus.disp_valid = 1'b0;
    bus.wake_valid = 4'b0000;
    step();
    check("race_valid", 64'(bus.iss_valid), 64'b001);
    check("race_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'd3);
    check("race_rs2", 64'(bus.iss_rs2_val[0 +: DATA_W]), 64'h55);
    check("race_rs1", 64'(bus.iss_rs1_val[0 +: DATA_W]), 64'h1);
    step();

    // Fill and drain
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 16; i++) begin
      disp(6'(i), 6'd1, 1'b1, 32'h100 + 32'(i), 6'd2, 1'b1, 32'h0);
      step();
    end
    check("fill_count", 64'(bus.count), 64'd16);
    check("fill_disp_ready", 64'(bus.disp_ready), 64'd0);
    disp(6'd63, 6'd1, 1'b1, 32'hBAD, 6'd2, 1'b1, 32'h0);
    step();
    bus.disp_valid = 1'b0;
    check("full_reject_count", 64'(bus.count), 64'd16);
    check("full_no_issue", 64'(bus.iss_valid), 64'd0);
    bus.fu_ready = 3'b101;
    for (int k = 0; k < 8; k++) begin
      step();
      check("drain_valid", 64'(bus.iss_valid), 64'b101);
      check("drain_fu0_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'(2*k));
      check("drain_fu2_rob", 64'(bus.iss_rob[2*ROB_W +: ROB_W]), 64'(2*k+1));
      check("drain_fu2_rs1", 64'(bus.iss_rs1_val[2*DATA_W +: DATA_W]), 64'(32'h100 + 32'(2*k+1)));
      check("drain_count", 64'(bus.count), 64'(16 - 2*(k+1)));
      check("drain_disp_ready", 64'(bus.disp_ready), 64'd1);
    end
    step();
    check("empty_no_issue", 64'(bus.iss_valid), 64'd0);

    // Flush against a same-cycle dispatch with 5 pending
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      disp(6'(40 + i), 6'd1, 1'b1, 32'h0, 6'd2, 1'b1, 32'h0);
      step();
    end
    check("pre_flush_count", 64'(bus.count), 64'd5);
    bus.fu_ready = 3'b111;
    bus.flush = 1'b1;
    disp(6'd50, 6'd1, 1'b1, 32'h0, 6'd2, 1'b1, 32'h0);
    step();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("flush_disp_ready", 64'(bus.disp_ready), 64'd1);
    step();
    check("post_flush_no_issue", 64'(bus.iss_valid), 64'd0);
    check("post_flush_count", 64'(bus.count), 64'd0);

    // Dispatch and issue in the same cycle leave count unchanged
    bus.fu_ready = 3'b001;
    disp(6'd20, 6'd1, 1'b1, 32'h0, 6'd2, 1'b1, 32'h0);
    step();
    disp(6'd21, 6'd1, 1'b1, 32'h0, 6'd2, 1'b1, 32'h0);
    step();
    bus.disp_valid = 1'b0;
    check("both_count", 64'(bus.count), 64'd1);
    check("both_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'd20);
    step();
    check("both_second_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'd21);
    check("both_final_count", 64'(bus.count), 64'd0);

    // Small configuration: fill, reject, drain one per cycle, race on bus 1
    for (int i = 0; i < 4; i++) begin
      disp2(6'(10 + i), 6'd1, 1'b1, 32'(i));
      step();
    end
    check("p_fill_count", 64'(bus2.count), 64'd4);
    check("p_disp_ready", 64'(bus2.disp_ready), 64'd0);
    disp2(6'd14, 6'd1, 1'b1, 32'h0);
    step();
    bus2.disp_valid = 1'b0;
    check("p_reject_count", 64'(bus2.count), 64'd4);
    bus2.fu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("p_drain_valid", 64'(bus2.iss_valid), 64'd1);
      check("p_drain_rob", 64'(bus2.iss_rob), 64'(10 + k));
      check("p_drain_count", 64'(bus2.count), 64'(3 - k));
    end
    step();
    check("p_empty", 64'(bus2.iss_valid), 64'd0);
    disp2(6'd33, 6'd5, 1'b0, 32'h0);
    bus2.wake_valid = 2'b10;
    bus2.wake_tag[TAG_W +: TAG_W]   = 6'd5;
    bus2.wake_val[DATA_W +: DATA_W] = 32'hAB;
    step();
    bus2.disp_valid = 1'b0;
    bus2.wake_valid = 2'b00;
    step();
    check("p_race_valid", 64'(bus2.iss_valid), 64'd1);
    check("p_race_rob", 64'(bus2.iss_rob), 64'd33);
    check("p_race_rs1", 64'(bus2.iss_rs1_val), 64'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
